// File: rtl/ctrl_fsm_if.sv
// Instruction-field and control-output bundle between the multicycle controller and the datapath.
// The master side drives the instruction fields; the slave side drives the control outputs.
interface ctrl_fsm_if;
  logic [1:0] Op;
  logic [5:0] Funct;
  logic [3:0] Rd;
  logic       IRWrite;
  logic       NextPC;
  logic       RegW;
  logic       MemW;
  logic       Branch;
  logic       PCS;
  logic       AdrSrc;
  logic       ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [1:0] ResultSrc;
  logic [1:0] ALUControl;
  logic [1:0] FlagW;
  logic [1:0] ImmSrc;
  logic [1:0] RegSrc;
  logic       Illegal;

  modport master (
    output Op, Funct, Rd,
    input  IRWrite, NextPC, RegW, MemW, Branch, PCS, AdrSrc, ALUSrcA,
    input  ALUSrcB, ResultSrc, ALUControl, FlagW, ImmSrc, RegSrc, Illegal
  );

  modport slave (
    input  Op, Funct, Rd,
    output IRWrite, NextPC, RegW, MemW, Branch, PCS, AdrSrc, ALUSrcA,
    output ALUSrcB, ResultSrc, ALUControl, FlagW, ImmSrc, RegSrc, Illegal
  );
endinterface

// File: rtl/ctrl_fsm.sv
// Moore controller for a multicycle ARM-subset datapath (fetch, decode, memory, DP, branch).
// Define CTRL_FSM_ILLEGAL_TRAP_EN to trap undefined opcodes and unsupported DP commands.
module ctrl_fsm (
  input  logic        clk,
  input  logic        reset,
  ctrl_fsm_if.slave   bus
);

  typedef enum logic [3:0] {
    FETCH,
    DECODE,
    MEMADR,
    MEMREAD,
    MEMWB,
    MEMWRITE,
    EXECUTER,
    EXECUTEI,
    ALUWB,
    BRANCH
`ifdef CTRL_FSM_ILLEGAL_TRAP_EN
    , ILLEGAL
`endif
  } state_t;

  state_t     r_state;
  state_t     w_next;
  logic       w_irwrite;
  logic       w_nextpc;
  logic       w_regw;
  logic       w_memw;
  logic       w_branch;
  logic       w_adrsrc;
  logic       w_alusrca;
  logic [1:0] w_alusrcb;
  logic [1:0] w_resultsrc;
  logic       w_aluop;
  logic       w_illegal;
  logic [1:0] w_alu_ctrl;
  logic [1:0] w_flagw;
  logic [3:0] w_cmd;

  assign w_cmd = bus.Funct[4:1];

`ifdef CTRL_FSM_ILLEGAL_TRAP_EN
  logic w_cmd_ok;
  assign w_cmd_ok = (w_cmd == 4'b0100) || (w_cmd == 4'b0010) ||
                    (w_cmd == 4'b0000) || (w_cmd == 4'b1100);
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= FETCH;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next      = r_state;
    w_irwrite   = 1'b0;
    w_nextpc    = 1'b0;
    w_regw      = 1'b0;
    w_memw      = 1'b0;
    w_branch    = 1'b0;
    w_adrsrc    = 1'b0;
    w_alusrca   = 1'b0;
    w_alusrcb   = 2'b00;
    w_resultsrc = 2'b00;
    w_aluop     = 1'b0;
    w_illegal   = 1'b0;
    case (r_state)
      FETCH: begin
        w_irwrite   = 1'b1;
        w_nextpc    = 1'b1;
        w_alusrca   = 1'b1;
        w_alusrcb   = 2'b10;
        w_resultsrc = 2'b10;
        w_next      = DECODE;
      end
      DECODE: begin
        w_alusrca   = 1'b1;
        w_alusrcb   = 2'b10;
        w_resultsrc = 2'b10;
        case (bus.Op)
          2'b00:   w_next = bus.Funct[5] ? EXECUTEI : EXECUTER;
          2'b01:   w_next = MEMADR;
          2'b10:   w_next = BRANCH;
`ifdef CTRL_FSM_ILLEGAL_TRAP_EN
          default: w_next = ILLEGAL;
`else
          default: w_next = FETCH;
`endif
        endcase
      end
      MEMADR: begin
        w_alusrcb = 2'b01;
        w_next    = bus.Funct[0] ? MEMREAD : MEMWRITE;
      end
      MEMREAD: begin
        w_adrsrc = 1'b1;
        w_next   = MEMWB;
      end
      MEMWB: begin
        w_resultsrc = 2'b01;
        w_regw      = 1'b1;
        w_next      = FETCH;
      end
      MEMWRITE: begin
        w_adrsrc = 1'b1;
        w_memw   = 1'b1;
        w_next   = FETCH;
      end
      EXECUTER, EXECUTEI: begin
        w_alusrcb = (r_state == EXECUTEI) ? 2'b01 : 2'b00;
        w_aluop   = 1'b1;
`ifdef CTRL_FSM_ILLEGAL_TRAP_EN
        w_next    = w_cmd_ok ? ALUWB : ILLEGAL;
`else
        w_next    = ALUWB;
`endif
      end
      ALUWB: begin
        w_regw = 1'b1;
        w_next = FETCH;
      end
      BRANCH: begin
        w_alusrcb   = 2'b01;
        w_resultsrc = 2'b10;
        w_branch    = 1'b1;
        w_next      = FETCH;
      end
`ifdef CTRL_FSM_ILLEGAL_TRAP_EN
      ILLEGAL: begin
        w_illegal = 1'b1;
        w_next    = ILLEGAL;
      end
`endif
      default: w_next = FETCH;
    endcase
  end

  always_comb begin
    w_alu_ctrl = 2'b00;
    if (w_aluop) begin
      case (w_cmd)
        4'b0100: w_alu_ctrl = 2'b00;
        4'b0010: w_alu_ctrl = 2'b01;
        4'b0000: w_alu_ctrl = 2'b10;
        4'b1100: w_alu_ctrl = 2'b11;
        default: w_alu_ctrl = 2'b00;
      endcase
    end
  end

  // Only ADD/SUB (ALUControl 0x) update the C/V flags.
  assign w_flagw[1] = w_aluop & bus.Funct[0];
  assign w_flagw[0] = w_flagw[1] & ~w_alu_ctrl[1];

  // Enables are forced low while reset is held, even though the state already reads FETCH.
  assign bus.IRWrite    = w_irwrite & ~reset;
  assign bus.NextPC     = w_nextpc  & ~reset;
  assign bus.RegW       = w_regw    & ~reset;
  assign bus.MemW       = w_memw    & ~reset;
  assign bus.Branch     = w_branch  & ~reset;
  assign bus.FlagW      = w_flagw   & {2{~reset}};
  assign bus.Illegal    = w_illegal & ~reset;
  assign bus.PCS        = (w_branch | (w_regw & (bus.Rd == 4'hF))) & ~reset;
  assign bus.AdrSrc     = w_adrsrc;
  assign bus.ALUSrcA    = w_alusrca;
  assign bus.ALUSrcB    = w_alusrcb;
  assign bus.ResultSrc  = w_resultsrc;
  assign bus.ALUControl = w_alu_ctrl;
  assign bus.ImmSrc     = bus.Op;
  assign bus.RegSrc     = {bus.Op == 2'b01, bus.Op == 2'b10};

endmodule

// File: tb/tb_ctrl_fsm.sv
// Directed self-checking bench for ctrl_fsm: walks each instruction class cycle by cycle
// and compares the full control-output vector against hand-derived values.
module tb_ctrl_fsm;
  logic clk;
  logic reset;
  int   checks;
  int   fails;

  ctrl_fsm_if bus ();

  ctrl_fsm dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not reach the summary");
    $fatal(1, "timeout");
  end

  // {IRWrite,NextPC,RegW,MemW,Branch,PCS,AdrSrc,ALUSrcA,ALUSrcB,ResultSrc,ALUControl,FlagW,ImmSrc,RegSrc,Illegal}
  logic [20:0] obs;
  assign obs = {bus.IRWrite, bus.NextPC, bus.RegW, bus.MemW, bus.Branch, bus.PCS,
                bus.AdrSrc, bus.ALUSrcA, bus.ALUSrcB, bus.ResultSrc, bus.ALUControl,
                bus.FlagW, bus.ImmSrc, bus.RegSrc, bus.Illegal};

  localparam logic [20:0] EN_MASK = 21'b111111_0_0_00_00_00_11_00_00_1;

  function automatic logic [20:0] ev(
    input logic ir, npc, regw, memw, br, pcs, adr, srca,
    input logic [1:0] srcb, rsrc, aluc, flagw, imms, regs,
    input logic ill);
    return {ir, npc, regw, memw, br, pcs, adr, srca, srcb, rsrc, aluc, flagw, imms, regs, ill};
  endfunction

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic test_reset();
    logic [20:0] e;
    reset = 1'b1;
    bus.Op = 2'b00; bus.Funct = 6'b101001; bus.Rd = 4'b0011;
    step(); step();
    e = ev(0,0,0,0,0,0,0,1,2'b10,2'b10,2'b00,2'b00,2'b00,2'b00,0);
    checks++;
    if (obs !== e) begin
      $display("FAIL reset_hold: got %h expected %h", obs, e); fails++;
    end
    reset = 1'b0;
    #1;
    e = ev(1,1,0,0,0,0,0,1,2'b10,2'b10,2'b00,2'b00,2'b00,2'b00,0);
    checks++;
    if (obs !== e) begin
      $display("FAIL reset_first_fetch: got %h expected %h", obs, e); fails++;
    end
    $display("test_reset done");
  endtask

  task automatic test_dp_imm();
    logic [20:0] e[5];
    bus.Op = 2'b00; bus.Funct = 6'b101001; bus.Rd = 4'b0011;
    #1;
    e[0] = ev(1,1,0,0,0,0,0,1,2'b10,2'b10,2'b00,2'b00,2'b00,2'b00,0);
    e[1] = ev(0,0,0,0,0,0,0,1,2'b10,2'b10,2'b00,2'b00,2'b00,2'b00,0);
    e[2] = ev(0,0,0,0,0,0,0,0,2'b01,2'b00,2'b00,2'b11,2'b00,2'b00,0);
    e[3] = ev(0,0,1,0,0,0,0,0,2'b00,2'b00,2'b00,2'b00,2'b00,2'b00,0);
    e[4] = e[0];
    for (int c = 0; c < 5; c++) begin
      checks++;
      if (obs !== e[c]) begin
        $display("FAIL adds_imm cycle %0d: got %h expected %h", c, obs, e[c]); fails++;
      end
      if (c != 4) step();
    end
    $display("test_dp_imm done");
  endtask

  task automatic test_dp_reg();
    logic [5:0] fn[4];
    logic [3:0] rd[4];
    logic [1:0] ac[4];
    logic [1:0] fw[4];
    logic       pc[4];
    logic [20:0] e[5];
    fn = '{6'b000100, 6'b000001, 6'b011001, 6'b000101};
    rd = '{4'b0001,   4'b1111,   4'b0100,   4'b1111};
    ac = '{2'b01,     2'b10,     2'b11,     2'b01};
    fw = '{2'b00,     2'b10,     2'b10,     2'b11};
    pc = '{1'b0,      1'b1,      1'b0,      1'b1};
    for (int t = 0; t < 4; t++) begin
      bus.Op = 2'b00; bus.Funct = fn[t]; bus.Rd = rd[t];
      #1;
      e[0] = ev(1,1,0,0,0,0,0,1,2'b10,2'b10,2'b00,2'b00,2'b00,2'b00,0);
      e[1] = ev(0,0,0,0,0,0,0,1,2'b10,2'b10,2'b00,2'b00,2'b00,2'b00,0);
      e[2] = ev(0,0,0,0,0,0,0,0,2'b00,2'b00,ac[t],fw[t],2'b00,2'b00,0);
      e[3] = ev(0,0,1,0,0,pc[t],0,0,2'b00,2'b00,2'b00,2'b00,2'b00,2'b00,0);
      e[4] = e[0];
      for (int c = 0; c < 5; c++) begin
        checks++;
        if (obs !== e[c]) begin
          $display("FAIL dp_reg%0d cycle %0d: got %h expected %h", t, c, obs, e[c]); fails++;
        end
        if (c != 4) step();
      end
    end
    $display("test_dp_reg done");
  endtask

  task automatic test_ldr();
    logic [20:0] e[6];
    bus.Op = 2'b01; bus.Funct = 6'b011001; bus.Rd = 4'b1111;
    #1;
    e[0] = ev(1,1,0,0,0,0,0,1,2'b10,2'b10,2'b00,2'b00,2'b01,2'b10,0);
    e[1] = ev(0,0,0,0,0,0,0,1,2'b10,2'b10,2'b00,2'b00,2'b01,2'b10,0);
    e[2] = ev(0,0,0,0,0,0,0,0,2'b01,2'b00,2'b00,2'b00,2'b01,2'b10,0);
    e[3] = ev(0,0,0,0,0,0,1,0,2'b00,2'b00,2'b00,2'b00,2'b01,2'b10,0);
    e[4] = ev(0,0,1,0,0,1,0,0,2'b00,2'b01,2'b00,2'b00,2'b01,2'b10,0);
    e[5] = e[0];
    for (int c = 0; c < 6; c++) begin
      checks++;
      if (obs !== e[c]) begin
        $display("FAIL ldr cycle %0d: got %h expected %h", c, obs, e[c]); fails++;
      end
      if (c != 5) step();
    end
    $display("test_ldr done");
  endtask

  task automatic test_str();
    logic [20:0] e[5];
    bus.Op = 2'b01; bus.Funct = 6'b011000; bus.Rd = 4'b1111;
    #1;
    e[0] = ev(1,1,0,0,0,0,0,1,2'b10,2'b10,2'b00,2'b00,2'b01,2'b10,0);
    e[1] = ev(0,0,0,0,0,0,0,1,2'b10,2'b10,2'b00,2'b00,2'b01,2'b10,0);
    e[2] = ev(0,0,0,0,0,0,0,0,2'b01,2'b00,2'b00,2'b00,2'b01,2'b10,0);
    e[3] = ev(0,0,0,1,0,0,1,0,2'b00,2'b00,2'b00,2'b00,2'b01,2'b10,0);
    e[4] = e[0];
    for (int c = 0; c < 5; c++) begin
      checks++;
      if (obs !== e[c]) begin
        $display("FAIL str cycle %0d: got %h expected %h", c, obs, e[c]); fails++;
      end
      if (c != 4) step();
    end
    $display("test_str done");
  endtask

  task automatic test_branch();
    logic [20:0] e[4];
    bus.Op = 2'b10; bus.Funct = 6'b000000; bus.Rd = 4'b0000;
    #1;
    e[0] = ev(1,1,0,0,0,0,0,1,2'b10,2'b10,2'b00,2'b00,2'b10,2'b01,0);
    e[1] = ev(0,0,0,0,0,0,0,1,2'b10,2'b10,2'b00,2'b00,2'b10,2'b01,0);
    e[2] = ev(0,0,0,0,1,1,0,0,2'b01,2'b10,2'b00,2'b00,2'b10,2'b01,0);
    e[3] = e[0];
    for (int c = 0; c < 4; c++) begin
      checks++;
      if (obs !== e[c]) begin
        $display("FAIL branch cycle %0d: got %h expected %h", c, obs, e[c]); fails++;
      end
      if (c != 3) step();
    end
    $display("test_branch done");
  endtask

  task automatic test_reset_mid();
    logic [20:0] e[4];
    logic [20:0] tail[4];
    bus.Op = 2'b01; bus.Funct = 6'b011001; bus.Rd = 4'b1111;
    #1;
    e[0] = ev(1,1,0,0,0,0,0,1,2'b10,2'b10,2'b00,2'b00,2'b01,2'b10,0);
    e[1] = ev(0,0,0,0,0,0,0,1,2'b10,2'b10,2'b00,2'b00,2'b01,2'b10,0);
    e[2] = ev(0,0,0,0,0,0,0,0,2'b01,2'b00,2'b00,2'b00,2'b01,2'b10,0);
    e[3] = ev(0,0,0,0,0,0,1,0,2'b00,2'b00,2'b00,2'b00,2'b01,2'b10,0);
    for (int c = 0; c < 4; c++) begin
      checks++;
      if (obs !== e[c]) begin
        $display("FAIL rst_mid_pre cycle %0d: got %h expected %h", c, obs, e[c]); fails++;
      end
      if (c != 3) step();
    end
    reset = 1'b1;
    #1;
    for (int c = 0; c < 2; c++) begin
      checks++;
      if ((obs & EN_MASK) !== 21'd0 || bus.ALUSrcA !== 1'b1) begin
        $display("FAIL rst_mid_hold%0d: got %h expected enables 0 and ALUSrcA 1", c, obs); fails++;
      end
      if (c == 0) step();
    end
    reset = 1'b0;
    #1;
    tail[0] = e[0]; tail[1] = e[1]; tail[2] = e[2]; tail[3] = e[3];
    for (int c = 0; c < 4; c++) begin
      checks++;
      if (obs !== tail[c]) begin
        $display("FAIL rst_mid_post cycle %0d: got %h expected %h", c, obs, tail[c]); fails++;
      end
      step();
    end
    e[0] = ev(0,0,1,0,0,1,0,0,2'b00,2'b01,2'b00,2'b00,2'b01,2'b10,0);
    checks++;
    if (obs !== e[0]) begin
      $display("FAIL rst_mid_memwb: got %h expected %h", obs, e[0]); fails++;
    end
    step();
    $display("test_reset_mid done");
  endtask

  task automatic test_undef();
    logic [20:0] e[5];
    bus.Op = 2'b11; bus.Funct = 6'b000000; bus.Rd = 4'b0000;
    #1;
    e[0] = ev(1,1,0,0,0,0,0,1,2'b10,2'b10,2'b00,2'b00,2'b11,2'b00,0);
    e[1] = ev(0,0,0,0,0,0,0,1,2'b10,2'b10,2'b00,2'b00,2'b11,2'b00,0);
`ifdef CTRL_FSM_ILLEGAL_TRAP_EN
    e[2] = ev(0,0,0,0,0,0,0,0,2'b00,2'b00,2'b00,2'b00,2'b11,2'b00,1);
    for (int c = 0; c < 12; c++) begin
      checks++;
      if (obs !== e[c < 2 ? c : 2]) begin
        $display("FAIL undef_trap cycle %0d: got %h expected %h", c, obs, e[c < 2 ? c : 2]); fails++;
      end
      if (c != 11) step();
    end
    reset = 1'b1;
    #1;
    checks++;
    if (bus.Illegal !== 1'b0) begin
      $display("FAIL undef_clear: Illegal got %b expected 0", bus.Illegal); fails++;
    end
    step();
    reset = 1'b0;
    #1;
    checks++;
    if (obs !== e[0]) begin
      $display("FAIL undef_refetch: got %h expected %h", obs, e[0]); fails++;
    end
    bus.Op = 2'b00; bus.Funct = 6'b001011;
    #1;
    e[0] = ev(1,1,0,0,0,0,0,1,2'b10,2'b10,2'b00,2'b00,2'b00,2'b00,0);
    e[1] = ev(0,0,0,0,0,0,0,1,2'b10,2'b10,2'b00,2'b00,2'b00,2'b00,0);
    e[2] = ev(0,0,0,0,0,0,0,0,2'b00,2'b00,2'b00,2'b11,2'b00,2'b00,0);
    e[3] = ev(0,0,0,0,0,0,0,0,2'b00,2'b00,2'b00,2'b00,2'b00,2'b00,1);
    e[4] = e[3];
    for (int c = 0; c < 5; c++) begin
      checks++;
      if (obs !== e[c]) begin
        $display("FAIL badcmd_trap cycle %0d: got %h expected %h", c, obs, e[c]); fails++;
      end
      if (c != 4) step();
    end
    reset = 1'b1;
    step();
    reset = 1'b0;
    #1;
`else
    e[2] = e[0];
    for (int c = 0; c < 3; c++) begin
      checks++;
      if (obs !== e[c]) begin
        $display("FAIL undef_nop cycle %0d: got %h expected %h", c, obs, e[c]); fails++;
      end
      if (c != 2) step();
    end
    bus.Op = 2'b00; bus.Funct = 6'b001011;
    #1;
    e[0] = ev(1,1,0,0,0,0,0,1,2'b10,2'b10,2'b00,2'b00,2'b00,2'b00,0);
    e[1] = ev(0,0,0,0,0,0,0,1,2'b10,2'b10,2'b00,2'b00,2'b00,2'b00,0);
    e[2] = ev(0,0,0,0,0,0,0,0,2'b00,2'b00,2'b00,2'b11,2'b00,2'b00,0);
    e[3] = ev(0,0,1,0,0,0,0,0,2'b00,2'b00,2'b00,2'b00,2'b00,2'b00,0);
    e[4] = e[0];
    for (int c = 0; c < 5; c++) begin
      checks++;
      if (obs !== e[c]) begin
        $display("FAIL badcmd_nop cycle %0d: got %h expected %h", c, obs, e[c]); fails++;
      end
      if (c != 4) step();
    end
`endif
    $display("test_undef done");
  endtask

  initial begin
    checks = 0;
    fails  = 0;
    test_reset();
    test_dp_imm();
    test_dp_reg();
    test_ldr();
    test_str();
    test_branch();
    test_reset_mid();
    test_undef();
    test_dp_imm();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/ctrl_fsm.md
CTRL_FSM -- requirements
Module: ctrl_fsm

Interface
REQ-001 SHALL have no parameters; every width is fixed.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 Op  input  2  instruction bits [27:26]: 00 data-processing, 01 memory, 10 branch, 11 undefined.
REQ-005 Funct  input  6  instruction bits [25:20]: [5] immediate, [4:1] cmd, [0] S (DP) or L (memory).
REQ-006 Rd  input  4  destination register index.
REQ-007 IRWrite, NextPC, RegW, MemW, Branch  output  1 each  per-state enables.
REQ-008 PCS, AdrSrc, ALUSrcA  output  1 each  PC-source request, address select, ALU A select (1 = PC).
REQ-009 ALUSrcB, ResultSrc, ALUControl, FlagW, ImmSrc, RegSrc  output  2 each.
REQ-010 Illegal  output  1  sticky undefined-instruction indication.

Function
REQ-011 SHALL be a Moore FSM with states FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECUTER, EXECUTEI, ALUWB, BRANCH, plus ILLEGAL when enabled (REQ-029).
REQ-012 Transitions: FETCH->DECODE; DECODE: Op=01->MEMADR, Op=00 & Funct[5]=0->EXECUTER, Op=00 & Funct[5]=1->EXECUTEI, Op=10->BRANCH.
REQ-013 MEMADR->MEMREAD if Funct[0]=1, else MEMWRITE; MEMREAD->MEMWB; EXECUTER/EXECUTEI->ALUWB; MEMWB, MEMWRITE, ALUWB, BRANCH->FETCH.
REQ-014 Instruction latency (first FETCH to next FETCH): LDR 5, STR 4, DP 4, B 3 cycles.
REQ-015 Outputs not listed for a state SHALL be 0.
REQ-016 FETCH: IRWrite=1, NextPC=1, ALUSrcA=1, ALUSrcB=10, ResultSrc=10.
REQ-017 DECODE: ALUSrcA=1, ALUSrcB=10, ResultSrc=10. MEMADR: ALUSrcB=01.
REQ-018 MEMREAD: AdrSrc=1. MEMWB: ResultSrc=01, RegW=1. MEMWRITE: AdrSrc=1, MemW=1.
REQ-019 EXECUTER: ALUSrcB=00, internal ALUOp=1. EXECUTEI: ALUSrcB=01, ALUOp=1. ALUWB: RegW=1.
REQ-020 BRANCH: ALUSrcB=01, ResultSrc=10, Branch=1.
REQ-021 ALUControl: ALUOp=0 -> 00 (ADD); ALUOp=1, cmd 0100->00, 0010->01, 0000->10, 1100->11; any other cmd -> 00.
REQ-022 FlagW[1] = ALUOp & Funct[0]; FlagW[0] = FlagW[1] & (ALUControl is 00 or 01); FlagW is nonzero for at most one cycle per instruction.
REQ-023 PCS = Branch | (RegW & Rd==1111), combinational on state and Rd.
REQ-024 ImmSrc = Op; RegSrc[0] = (Op==10); RegSrc[1] = (Op==01); both combinational, valid in every state.
REQ-025 The downstream conditional-execution stage gates RegW, MemW, FlagW and PCS; this block SHALL NOT evaluate condition codes.

Reset
REQ-026 While reset=1: state=FETCH immediately (asynchronous); IRWrite, NextPC, RegW, MemW, Branch, PCS, FlagW and Illegal SHALL be 0.
REQ-027 The first FETCH enables SHALL assert in the first cycle after reset deasserts.
REQ-028 Reset asserted in any state, including mid-instruction, SHALL abandon the instruction with no further enable pulses.

Configuration
REQ-029 Macro CTRL_FSM_ILLEGAL_TRAP_EN. Defined: DECODE with Op=11, or EXECUTER/EXECUTEI with an unsupported cmd (in place of ALUWB), SHALL go to ILLEGAL. ILLEGAL holds with all enables 0 and Illegal=1 until reset.
REQ-030 Macro not defined: no ILLEGAL state; DECODE with Op=11 SHALL return to FETCH (2-cycle no-op); unsupported cmd follows REQ-019/021; Illegal tied 0.

Verification
REQ-031 Release reset, Op=00, Funct=101001 (ADDS imm), Rd=0011 -> F,D,EXECUTEI,ALUWB; FlagW=11 only in EXECUTEI; RegW=1 only in ALUWB; PCS=0.
REQ-032 Op=01, Funct=011001 (LDR), Rd=1111 -> F,D,MEMADR,MEMREAD,MEMWB; AdrSrc=1 in MEMREAD; PCS=1 in MEMWB.
REQ-033 Op=01, Funct[0]=0 (STR) -> MemW=1 only in MEMWRITE; back to FETCH after 4 cycles; RegW never 1.
REQ-034 Op=10 -> F,D,BRANCH; Branch=1, PCS=1, ALUSrcB=01 in BRANCH; RegSrc=01, ImmSrc=10 throughout.
REQ-035 Assert reset in MEMREAD of an LDR -> state FETCH, RegW=0 during reset; IRWrite=1 the cycle after release.
REQ-036 Op=11 -> with CTRL_FSM_ILLEGAL_TRAP_EN: Illegal=1 from the cycle after DECODE, held for 10 cycles, cleared by reset; without the macro: back to FETCH, Illegal=0.
